// File: rtl/half_adder_dataflow_pkg.sv
//------------------------------------------------------------------------------
// Module   : half_adder_dataflow_pkg
// Purpose  : Shared width bounds, lane-result type and evaluation helper for
//            the half-adder family (reused by the full-adder block).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package half_adder_dataflow_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  typedef struct packed {
    logic carry;
    logic sum;
  } ha_result_t;

  function automatic ha_result_t ha_eval(input logic a, input logic b);
    ha_result_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/half_adder_bit.sv
//------------------------------------------------------------------------------
// Module   : half_adder_bit
// Purpose  : Single-lane combinational half adder (XOR sum, AND carry).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module half_adder_bit
  import half_adder_dataflow_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  ha_result_t res;

  assign res   = ha_eval(a, b);
  assign sum   = res.sum;
  assign carry = res.carry;

endmodule

`default_nettype wire

// File: rtl/half_adder_dataflow.sv
//------------------------------------------------------------------------------
// Module   : half_adder_dataflow
// Purpose  : WIDTH-lane half adder with zero-latency outputs plus a one-stage
//            registered copy qualified by out_valid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module half_adder_dataflow
  import half_adder_dataflow_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
);

  generate
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
      $error("half_adder_dataflow: WIDTH out of range");
    end
  endgenerate

  // Lanes are independent: no carry ever crosses between bit positions.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
        .a     (a[i]),
        .b     (b[i]),
        .sum   (sum[i]),
        .carry (carry[i])
      );
    end
  endgenerate

  // Data registers hold when no new operand arrives; only the valid flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum_q     <= sum;
      carry_q   <= carry;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_half_adder_dataflow.sv
//------------------------------------------------------------------------------
// Module   : tb_half_adder_dataflow
// Purpose  : Self-checking bench for half_adder_dataflow at WIDTH=1 and WIDTH=8.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_half_adder_dataflow;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a1, b1, v1;
  logic       s1, c1, sq1, cq1, ov1;
  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] s8, c8, sq8, cq8;
  logic       ov8;

  int checks = 0;
  int errors = 0;

  half_adder_dataflow #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
  );

  half_adder_dataflow #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .sum(s8), .carry(c8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each lane is an arithmetic add of two bits; result bit 0 is
  // the sum, bit 1 the carry.
  function automatic logic [15:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] rs, rc;
    int t;
    for (int i = 0; i < 8; i++) begin
      t     = int'(x[i]) + int'(y[i]);
      rs[i] = (t % 2) == 1;
      rc[i] = (t / 2) == 1;
    end
    return {rc, rs};
  endfunction

  logic [15:0] r;
  logic [7:0]  exp_sq, exp_cq, prev_s, prev_c;
  logic        exp_ov;
  logic [1:0]  tt_in [4];
  logic [1:0]  tt_out[4];

  initial begin
    tt_in[0] = 2'b00; tt_out[0] = 2'b00;
    tt_in[1] = 2'b01; tt_out[1] = 2'b01;
    tt_in[2] = 2'b10; tt_out[2] = 2'b01;
    tt_in[3] = 2'b11; tt_out[3] = 2'b10;

    // Reset with unknown operands: registered outputs must become 0.
    rst = 1'b1; a1 = 1'bx; b1 = 1'bx; v1 = 1'b1;
    a8 = 'x; b8 = 'x; v8 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_sq1", 64'(sq1), 64'd0);
    chk("rst_cq1", 64'(cq1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_sq8", 64'(sq8), 64'd0);
    chk("rst_cq8", 64'(cq8), 64'd0);
    chk("rst_ov8", 64'(ov8), 64'd0);

    // Exhaustive truth table on the combinational path.
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      a1 = tt_in[k][1]; b1 = tt_in[k][0];
      #5;
      chk("tt_sum",   64'(s1), 64'(tt_out[k][0]));
      chk("tt_carry", 64'(c1), 64'(tt_out[k][1]));
      #5;
    end

    // Registered path: one valid beat then hold.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    chk("reg_sq", 64'(sq1), 64'd0);
    chk("reg_cq", 64'(cq1), 64'd1);
    chk("reg_ov", 64'(ov1), 64'd1);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    chk("hold_ov", 64'(ov1), 64'd0);
    chk("hold_sq", 64'(sq1), 64'd0);
    chk("hold_cq", 64'(cq1), 64'd1);

    // Reset priority over in_valid: the loaded carry must be cleared.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("prio_ov", 64'(ov1), 64'd0);
    chk("prio_cq", 64'(cq1), 64'd0);

    // Reset held two cycles with valid data; combinational path unaffected.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    #1;
    chk("rstc_sum",   64'(s1), 64'd1);
    chk("rstc_carry", 64'(c1), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rsth_sq", 64'(sq1), 64'd0);
      chk("rsth_cq", 64'(cq1), 64'd0);
      chk("rsth_ov", 64'(ov1), 64'd0);
    end

    // Multi-lane directed vector.
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
    #1;
    chk("ml_sum",   64'(s8), 64'h3C);
    chk("ml_carry", 64'(c8), 64'hC0);
    @(posedge clk); #1;
    chk("ml_sq", 64'(sq8), 64'h3C);
    chk("ml_cq", 64'(cq8), 64'hC0);
    chk("ml_ov", 64'(ov8), 64'd1);
    exp_sq = 8'h3C; exp_cq = 8'hC0;

    // Random vectors against the arithmetic reference.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      #1;
      r = ref_add(a8, b8);
      chk("rnd_sum",   64'(s8), 64'(r[7:0]));
      chk("rnd_carry", 64'(c8), 64'(r[15:8]));
      chk("rnd_excl",  64'(s8 & c8), 64'd0);
      exp_ov = v8;
      prev_s = s8; prev_c = c8;
      if (v8) begin
        exp_sq = r[7:0];
        exp_cq = r[15:8];
      end
      @(posedge clk); #1;
      chk("rnd_ov", 64'(ov8), 64'(exp_ov));
      chk("rnd_sq", 64'(sq8), 64'(exp_sq));
      chk("rnd_cq", 64'(cq8), 64'(exp_cq));
      if (ov8) begin
        chk("rnd_sq_prev", 64'(sq8), 64'(prev_s));
        chk("rnd_cq_prev", 64'(cq8), 64'(prev_c));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/half_adder_dataflow.md
Name: half_adder_dataflow

Overview:
- Bit-parallel half adder: for each bit i, sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i].
- Provides combinational (zero-latency) outputs for glue logic.
- Also provides a one-stage registered copy with a valid flag for timing-critical consumers.
- Leaf arithmetic primitive, used as a building block for full adders and ripple/carry-save structures.

Parameters:
- WIDTH, 1, number of independent bit lanes; legal range 1..64.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies a/b for the registered path.
- sum  output  WIDTH  combinational a XOR b.
- carry  output  WIDTH  combinational a AND b.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  registered in_valid; qualifies sum_q and carry_q.

Behaviour:
- Interface: single clock (clk); reset rst is synchronous and active-high.
- Combinational path:
  - sum = a ^ b and carry = a & b, bitwise per lane, with no clock dependence.
  - This path is not affected by rst or in_valid.
  - Lanes are fully independent; there is no carry propagation between lanes.
- 1-bit truth table (a b -> sum carry): 0 0 -> 0 0; 0 1 -> 1 0; 1 0 -> 1 0; 1 1 -> 0 1.
- Invariant, all lanes: sum & carry == 0, and {carry,sum} as a 2-bit value equals a + b.
- Registered path, on each rising clk edge:
  - If rst = 1: sum_q <= 0, carry_q <= 0, out_valid <= 0.
  - Else if in_valid = 1: sum_q <= a ^ b, carry_q <= a & b, out_valid <= 1.
  - Else: sum_q and carry_q hold their previous values, out_valid <= 0.
- Latency: 1 cycle from in_valid to out_valid. Throughput: one result per cycle.
- Reset mid-stream: rst has priority over in_valid in the same cycle. The pending result is discarded and out_valid is 0 on the next cycle.
- Reset values: sum_q = 0, carry_q = 0, out_valid = 0.
  - sum and carry have no reset value; they follow their inputs.
- X-handling: the registered outputs must be known (0) after the first reset edge, regardless of the a/b values.

Decomposition:
- Shared package: the WIDTH bounds constant (max 64), and a typedef for a lane-result struct {carry, sum}, for reuse by the full-adder block.
- One natural sub-module: half_adder_bit, a single-lane combinational XOR/AND cell.
  - The top instantiates it WIDTH times in a generate loop.
  - The top adds the output register stage and the valid flag.

Test Plan:
- Exhaustive truth table, WIDTH=1, combinational path: apply 00, 01, 10, 11, holding each for 10 time units.
  - Required sum/carry: 0/0, 1/0, 1/0, 0/1.
- Registered path, WIDTH=1: with rst low, present a=1, b=1, in_valid=1 for one cycle.
  - Required next cycle: sum_q=0, carry_q=1, out_valid=1.
  - Following cycle, with in_valid=0: out_valid=0 and sum_q/carry_q hold 0/1.
- Reset: drive rst=1 for 2 cycles with a=1, b=0, in_valid=1.
  - Required: sum_q=0, carry_q=0, out_valid=0 throughout.
  - Combinational sum=1 and carry=0 during reset.
- Reset priority: assert rst and in_valid in the same cycle with a=1, b=1.
  - Required next cycle: out_valid=0, carry_q=0.
- Multi-lane, WIDTH=8: a=8'hF0, b=8'hCC.
  - Required: sum=8'h3C, carry=8'hC0, and after one valid cycle sum_q=8'h3C, carry_q=8'hC0.
- Random, WIDTH=8, 1000 vectors: check sum & carry == 0 and {carry,sum} per lane equals a+b.
  - Check that the registered outputs match the combinational values from one cycle earlier whenever out_valid=1.
